// File: rtl/des_pkg.sv
// DES key schedule constants: widths, PC1/PC2 select tables, shift schedule, half rotations.
// Purely declarative; no logic is instantiated from this package.
package des_pkg;

    localparam int KEY_W    = 64;
    localparam int CD_W     = 56;
    localparam int HALF_W   = 28;
    localparam int SUBKEY_W = 48;

    // Left-rotate amount applied to C/D before each round (entry 1 = round 1).
    localparam logic [1:0] SHIFT_TBL [1:16] = '{
        2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
        2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
    };

    // Tables hold DES bit numbers (1 = MSB of the source vector); element 0 feeds the output MSB.
    localparam logic [0:55][7:0] PC1_TBL = {
        8'd57, 8'd49, 8'd41, 8'd33, 8'd25, 8'd17, 8'd9,  8'd1,
        8'd58, 8'd50, 8'd42, 8'd34, 8'd26, 8'd18, 8'd10, 8'd2,
        8'd59, 8'd51, 8'd43, 8'd35, 8'd27, 8'd19, 8'd11, 8'd3,
        8'd60, 8'd52, 8'd44, 8'd36, 8'd63, 8'd55, 8'd47, 8'd39,
        8'd31, 8'd23, 8'd15, 8'd7,  8'd62, 8'd54, 8'd46, 8'd38,
        8'd30, 8'd22, 8'd14, 8'd6,  8'd61, 8'd53, 8'd45, 8'd37,
        8'd29, 8'd21, 8'd13, 8'd5,  8'd28, 8'd20, 8'd12, 8'd4
    };

    localparam logic [0:47][7:0] PC2_TBL = {
        8'd14, 8'd17, 8'd11, 8'd24, 8'd1,  8'd5,  8'd3,  8'd28,
        8'd15, 8'd6,  8'd21, 8'd10, 8'd23, 8'd19, 8'd12, 8'd4,
        8'd26, 8'd8,  8'd16, 8'd7,  8'd27, 8'd20, 8'd13, 8'd2,
        8'd41, 8'd52, 8'd31, 8'd37, 8'd47, 8'd55, 8'd30, 8'd40,
        8'd51, 8'd45, 8'd33, 8'd48, 8'd44, 8'd49, 8'd39, 8'd56,
        8'd34, 8'd53, 8'd46, 8'd42, 8'd50, 8'd36, 8'd29, 8'd32
    };

    typedef enum logic {ST_IDLE, ST_RUN} state_t;

    // Out-of-range rounds return 0 so the half simply holds.
    function automatic logic [1:0] shift_amt(input int r);
        logic [1:0] amt;
        amt = 2'd0;
        for (int i = 1; i <= 16; i++) begin
            if (r == i) amt = SHIFT_TBL[i];
        end
        return amt;
    endfunction

    function automatic logic [HALF_W-1:0] rotl(input logic [HALF_W-1:0] x, input logic [1:0] n);
        case (n)
            2'd1:    return {x[HALF_W-2:0], x[HALF_W-1]};
            2'd2:    return {x[HALF_W-3:0], x[HALF_W-1:HALF_W-2]};
            default: return x;
        endcase
    endfunction

    function automatic logic [HALF_W-1:0] rotr(input logic [HALF_W-1:0] x, input logic [1:0] n);
        case (n)
            2'd1:    return {x[0], x[HALF_W-1:1]};
            2'd2:    return {x[1:0], x[HALF_W-1:2]};
            default: return x;
        endcase
    endfunction

endpackage

// File: rtl/des_key_schedule_pc1.sv
// DES permuted choice 1: 64-bit key to 56-bit C/D, parity bits dropped.
// Latency: combinational.
// Backpressure: none, pure wiring.
module des_key_schedule_pc1
    import des_pkg::*;
(
    input  logic [KEY_W-1:0] key,
    output logic [CD_W-1:0]  cd
);

    for (genvar i = 0; i < CD_W; i++) begin : g_sel
        localparam int SRC = KEY_W - int'(PC1_TBL[i]);
        assign cd[CD_W-1-i] = key[SRC];
    end

    logic unused_parity;
    assign unused_parity = ^{key[56], key[48], key[40], key[32], key[24], key[16], key[8], key[0]};

endmodule

// File: rtl/des_key_schedule_pc2.sv
// DES permuted choice 2: 56-bit C/D to 48-bit round key.
// Latency: combinational.
// Backpressure: none, pure wiring.
module des_key_schedule_pc2
    import des_pkg::*;
(
    input  logic [CD_W-1:0]     cd,
    output logic [SUBKEY_W-1:0] subkey
);

    for (genvar i = 0; i < SUBKEY_W; i++) begin : g_sel
        localparam int SRC = CD_W - int'(PC2_TBL[i]);
        assign subkey[SUBKEY_W-1-i] = cd[SRC];
    end

    // DES bits 9,18,22,25,35,38,43,54 are never selected by PC2.
    logic unused_bits;
    assign unused_bits = ^{cd[47], cd[38], cd[34], cd[31], cd[21], cd[18], cd[13], cd[2]};

endmodule

// File: rtl/des_key_schedule.sv
// Sequential DES subkey generator: one 48-bit round key per valid/ready handshake, encrypt or decrypt order.
// Latency: first key one cycle after start; then one key per cycle while i_Ready is high.
// Backpressure: o_Valid & !i_Ready holds C/D and o_Round; DES_KEY_PARITY_CHK_EN adds o_Parity_Err.
module des_key_schedule
    import des_pkg::*;
(
    input  logic                i_Clk,
    input  logic                i_Rst_n,
    input  logic                i_Start,
    input  logic [KEY_W-1:0]    i_Key,
    input  logic                i_Decrypt,
    input  logic                i_Ready,
    output logic                o_Valid,
    output logic [SUBKEY_W-1:0] o_Subkey,
    output logic [3:0]          o_Round,
    output logic                o_Busy,
    output logic                o_Done
`ifdef DES_KEY_PARITY_CHK_EN
    ,
    output logic                o_Parity_Err
`endif
);

    state_t              state, state_nxt;
    logic [HALF_W-1:0]   c_q, d_q, c_nxt, d_nxt;
    logic [3:0]          round_nxt;
    logic                dec_q, dec_nxt;
    logic                done_nxt;
    logic [CD_W-1:0]     pc1_cd;
    logic                hs;
    logic                last;

    des_key_schedule_pc1 u_pc1 (
        .key (i_Key),
        .cd  (pc1_cd)
    );

    des_key_schedule_pc2 u_pc2 (
        .cd     ({c_q, d_q}),
        .subkey (o_Subkey)
    );

    assign o_Valid = (state == ST_RUN);
    assign o_Busy  = (state == ST_RUN);
    assign hs      = o_Valid & i_Ready;
    assign last    = dec_q ? (o_Round == 4'd0) : (o_Round == 4'd15);

    always_comb begin
        state_nxt = state;
        c_nxt     = c_q;
        d_nxt     = d_q;
        round_nxt = o_Round;
        dec_nxt   = dec_q;
        done_nxt  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (i_Start) begin
                    state_nxt = ST_RUN;
                    dec_nxt   = i_Decrypt;
                    if (i_Decrypt) begin
                        // C16/D16 equal C0/D0 because the shifts total 28.
                        c_nxt     = pc1_cd[CD_W-1:HALF_W];
                        d_nxt     = pc1_cd[HALF_W-1:0];
                        round_nxt = 4'd15;
                    end else begin
                        c_nxt     = rotl(pc1_cd[CD_W-1:HALF_W], 2'd1);
                        d_nxt     = rotl(pc1_cd[HALF_W-1:0], 2'd1);
                        round_nxt = 4'd0;
                    end
                end
            end
            ST_RUN: begin
                if (hs) begin
                    if (last) begin
                        state_nxt = ST_IDLE;
                        done_nxt  = 1'b1;
                    end
                    if (dec_q) begin
                        c_nxt     = rotr(c_q, shift_amt(int'(o_Round) + 1));
                        d_nxt     = rotr(d_q, shift_amt(int'(o_Round) + 1));
                        round_nxt = o_Round - 4'd1;
                    end else begin
                        c_nxt     = rotl(c_q, shift_amt(int'(o_Round) + 2));
                        d_nxt     = rotl(d_q, shift_amt(int'(o_Round) + 2));
                        round_nxt = o_Round + 4'd1;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state   <= ST_IDLE;
            c_q     <= '0;
            d_q     <= '0;
            o_Round <= 4'd0;
            dec_q   <= 1'b0;
            o_Done  <= 1'b0;
        end else begin
            state   <= state_nxt;
            c_q     <= c_nxt;
            d_q     <= d_nxt;
            o_Round <= round_nxt;
            dec_q   <= dec_nxt;
            o_Done  <= done_nxt;
        end
    end

`ifdef DES_KEY_PARITY_CHK_EN
    // DES key bytes must have odd parity; any even byte flags the key.
    logic key_par_bad;
    assign key_par_bad = ~^i_Key[7:0]   | ~^i_Key[15:8]  | ~^i_Key[23:16] | ~^i_Key[31:24] |
                         ~^i_Key[39:32] | ~^i_Key[47:40] | ~^i_Key[55:48] | ~^i_Key[63:56];

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            o_Parity_Err <= 1'b0;
        end else if (i_Start && state == ST_IDLE) begin
            o_Parity_Err <= key_par_bad;
        end
    end
`endif

endmodule

// File: tb/tb_des_key_schedule.sv
// Directed bench for des_key_schedule with a scoreboard of expected {round, subkey} pairs.
// Expected keys come from an independent cumulative-shift DES key schedule model.
module tb_des_key_schedule;

    logic        i_Clk, i_Rst_n, i_Start, i_Decrypt, i_Ready;
    logic [63:0] i_Key;
    logic        o_Valid, o_Busy, o_Done;
    logic [47:0] o_Subkey;
    logic [3:0]  o_Round;
`ifdef DES_KEY_PARITY_CHK_EN
    logic        o_Parity_Err;
`endif

    des_key_schedule dut (
        .i_Clk     (i_Clk),
        .i_Rst_n   (i_Rst_n),
        .i_Start   (i_Start),
        .i_Key     (i_Key),
        .i_Decrypt (i_Decrypt),
        .i_Ready   (i_Ready),
        .o_Valid   (o_Valid),
        .o_Subkey  (o_Subkey),
        .o_Round   (o_Round),
        .o_Busy    (o_Busy),
        .o_Done    (o_Done)
`ifdef DES_KEY_PARITY_CHK_EN
        ,
        .o_Parity_Err (o_Parity_Err)
`endif
    );

    initial begin
        i_Clk = 1'b0;
        forever #5 i_Clk = ~i_Clk;
    end

    localparam logic [63:0] KEY_A = 64'h133457799BBCDFF1;
    localparam logic [63:0] KEY_B = 64'h0E329232EA6D0D73;

    int pc1_t [56] = '{57,49,41,33,25,17,9,1,58,50,42,34,26,18,10,2,59,51,43,35,27,19,11,3,
                       60,52,44,36,63,55,47,39,31,23,15,7,62,54,46,38,30,22,14,6,61,53,45,37,
                       29,21,13,5,28,20,12,4};
    int pc2_t [48] = '{14,17,11,24,1,5,3,28,15,6,21,10,23,19,12,4,26,8,16,7,27,20,13,2,
                       41,52,31,37,47,55,30,40,51,45,33,48,44,49,39,56,34,53,46,42,50,36,29,32};
    int sh_t [16]  = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};

    typedef struct {
        logic [3:0]  rnd;
        logic [47:0] key;
    } exp_t;

    exp_t        q[$];
    int          checks = 0;
    int          errors = 0;
    int          done_cnt = 0;
    int          hs_cnt = 0;
    bit          done_pend = 0;
    bit          stall_pend = 0;
    logic [47:0] held_key;
    logic [3:0]  held_round;

    // K_n computed from C0/D0 with the total rotation applied in one go.
    function automatic logic [47:0] ref_key(input logic [63:0] key, input int n);
        logic [55:0] cd;
        logic [27:0] c, d;
        logic [47:0] k;
        int          tot;
        for (int i = 0; i < 56; i++) cd[6'(55 - i)] = key[6'(64 - pc1_t[i])];
        c = cd[55:28];
        d = cd[27:0];
        tot = 0;
        for (int j = 0; j < n; j++) tot += sh_t[j];
        for (int j = 0; j < tot; j++) begin
            c = {c[26:0], c[27]};
            d = {d[26:0], d[27]};
        end
        cd = {c, d};
        for (int i = 0; i < 48; i++) k[6'(47 - i)] = cd[6'(56 - pc2_t[i])];
        return k;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic fail_now(input string tag);
        checks++;
        errors++;
        $error("FAIL %s: observed timeout expected DUT event", tag);
    endtask

    // Called #1 after inputs are driven at the negedge; predicts the coming posedge.
    task automatic monitor();
        bit   accept;
        exp_t e;
        accept = i_Start && (q.size() == 0) && i_Rst_n;
        chk("valid", {63'd0, o_Valid}, {63'd0, q.size() != 0});
        chk("busy", {63'd0, o_Busy}, {63'd0, q.size() != 0});
        chk("done", {63'd0, o_Done}, {63'd0, done_pend});
        if (o_Done) done_cnt++;
        done_pend = 0;
        if (stall_pend) begin
            chk("hold_key", {16'd0, o_Subkey}, {16'd0, held_key});
            chk("hold_round", {60'd0, o_Round}, {60'd0, held_round});
        end
        stall_pend = 0;
        if (o_Valid && i_Ready && q.size() != 0) begin
            e = q.pop_front();
            chk("round", {60'd0, o_Round}, {60'd0, e.rnd});
            chk("subkey", {16'd0, o_Subkey}, {16'd0, e.key});
            hs_cnt++;
            if (q.size() == 0) done_pend = 1;
        end else if (o_Valid) begin
            stall_pend = 1;
            held_key   = o_Subkey;
            held_round = o_Round;
        end
        if (accept) begin
            for (int n = 1; n <= 16; n++) begin
                e.rnd = i_Decrypt ? 4'(16 - n) : 4'(n - 1);
                e.key = ref_key(i_Key, i_Decrypt ? 17 - n : n);
                q.push_back(e);
            end
        end
    endtask

    task automatic cycle(input logic rdy, input logic st, input logic [63:0] key, input logic dec);
        @(negedge i_Clk);
        i_Ready   = rdy;
        i_Start   = st;
        i_Key     = key;
        i_Decrypt = dec;
        #1 monitor();
    endtask

    task automatic run_until_empty(input bit rand_rdy, input int budget);
        int n;
        n = 0;
        while (q.size() != 0 && n < budget) begin
            cycle(rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1, 1'b0, 64'd0, 1'b0);
            n++;
        end
        if (q.size() != 0) fail_now("drain");
    endtask

    initial begin
        int d0, h0;
        bit found;
        i_Rst_n = 1'b0; i_Start = 1'b0; i_Key = '0; i_Decrypt = 1'b0; i_Ready = 1'b0;
        #2;
        chk("rst_valid", {63'd0, o_Valid}, 64'd0);
        chk("rst_busy", {63'd0, o_Busy}, 64'd0);
        chk("rst_done", {63'd0, o_Done}, 64'd0);
        chk("rst_subkey", {16'd0, o_Subkey}, 64'd0);
        chk("rst_round", {60'd0, o_Round}, 64'd0);
        @(negedge i_Clk);
        i_Rst_n = 1'b1;
        cycle(1'b1, 1'b0, 64'd0, 1'b0);

        // Encrypt, always ready
        d0 = done_cnt;
        cycle(1'b1, 1'b1, KEY_A, 1'b0);
        cycle(1'b1, 1'b0, 64'd0, 1'b0);
        chk("enc_k1_round", {60'd0, o_Round}, 64'd0);
        chk("enc_k1_const", {16'd0, o_Subkey}, 64'h1B02EFFC7072);
        for (int i = 0; i < 15; i++) cycle(1'b1, 1'b0, 64'd0, 1'b0);
        chk("enc_k16_round", {60'd0, o_Round}, 64'd15);
        chk("enc_k16_const", {16'd0, o_Subkey}, 64'hCB3D8B0E17F5);
        cycle(1'b1, 1'b0, 64'd0, 1'b0);
        cycle(1'b1, 1'b0, 64'd0, 1'b0);
        chk("enc_done_once", done_cnt - d0, 64'd1);

        // Decrypt, same key
        d0 = done_cnt;
        cycle(1'b1, 1'b1, KEY_A, 1'b1);
        cycle(1'b1, 1'b0, 64'd0, 1'b0);
        chk("dec_first_round", {60'd0, o_Round}, 64'd15);
        chk("dec_first_const", {16'd0, o_Subkey}, 64'hCB3D8B0E17F5);
        for (int i = 0; i < 15; i++) cycle(1'b1, 1'b0, 64'd0, 1'b0);
        chk("dec_last_round", {60'd0, o_Round}, 64'd0);
        chk("dec_last_const", {16'd0, o_Subkey}, 64'h1B02EFFC7072);
        cycle(1'b1, 1'b0, 64'd0, 1'b0);
        cycle(1'b1, 1'b0, 64'd0, 1'b0);
        chk("dec_done_once", done_cnt - d0, 64'd1);

        // Backpressure with random ready
        h0 = hs_cnt;
        d0 = done_cnt;
        cycle(1'b0, 1'b1, KEY_B, 1'b0);
        run_until_empty(1'b1, 400);
        cycle(1'b0, 1'b0, 64'd0, 1'b0);
        chk("bp_handshakes", hs_cnt - h0, 64'd16);
        chk("bp_done_once", done_cnt - d0, 64'd1);

        // Busy protection, then back-to-back start in the done cycle
        cycle(1'b1, 1'b1, KEY_A, 1'b0);
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            cycle(1'b1, 1'b0, 64'd0, 1'b0);
            if (o_Valid && o_Round == 4'd5) found = 1;
        end
        if (!found) fail_now("busy_round5");
        cycle(1'b1, 1'b1, KEY_B, 1'b1);
        run_until_empty(1'b0, 40);
        cycle(1'b1, 1'b1, KEY_B, 1'b0);
        chk("b2b_done_cycle", {63'd0, o_Done}, 64'd1);
        cycle(1'b1, 1'b0, 64'd0, 1'b0);
        chk("b2b_valid", {63'd0, o_Valid}, 64'd1);
        chk("b2b_k1", {16'd0, o_Subkey}, {16'd0, ref_key(KEY_B, 1)});

        // Async reset at round 8
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            cycle(1'b1, 1'b0, 64'd0, 1'b0);
            if (o_Valid && o_Round == 4'd8) found = 1;
        end
        if (!found) fail_now("reset_round8");
        q.delete();
        done_pend  = 0;
        stall_pend = 0;
        d0 = done_cnt;
        #2 i_Rst_n = 1'b0;
        #1;
        chk("arst_valid", {63'd0, o_Valid}, 64'd0);
        chk("arst_busy", {63'd0, o_Busy}, 64'd0);
        chk("arst_done", {63'd0, o_Done}, 64'd0);
        chk("arst_subkey", {16'd0, o_Subkey}, 64'd0);
        chk("arst_round", {60'd0, o_Round}, 64'd0);
        cycle(1'b1, 1'b0, 64'd0, 1'b0);
        cycle(1'b1, 1'b0, 64'd0, 1'b0);
        @(negedge i_Clk);
        i_Rst_n = 1'b1;
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 64'd0, 1'b0);
        chk("arst_no_done", done_cnt - d0, 64'd0);

`ifdef DES_KEY_PARITY_CHK_EN
        cycle(1'b1, 1'b1, 64'h0101010101010101, 1'b0);
        cycle(1'b1, 1'b0, 64'd0, 1'b0);
        chk("parity_good", {63'd0, o_Parity_Err}, 64'd0);
        run_until_empty(1'b0, 40);
        cycle(1'b1, 1'b0, 64'd0, 1'b0);
        cycle(1'b1, 1'b1, 64'h0001010101010101, 1'b0);
        cycle(1'b1, 1'b0, 64'd0, 1'b0);
        chk("parity_bad", {63'd0, o_Parity_Err}, 64'd1);
        chk("parity_bad_valid", {63'd0, o_Valid}, 64'd1);
        run_until_empty(1'b0, 40);
        cycle(1'b1, 1'b0, 64'd0, 1'b0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
